multicycle_control: RTL

- Multicycle control FSM for the single-issue RV32I datapath.
- Sequences each instruction through IF/ID/EX/MEM/WB and decodes the held instruction into datapath control: PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl.
- Drives data-memory read/write strobes with a ready handshake and counts retired instructions.
- Sits between instruction/data memories and the datapath; shares clk/rst with the datapath.

---
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle IF/ID/EX/MEM/WB control FSM for the RV32I datapath
//
// Purpose:
//   Steps each instruction through IF, ID, EX, MEM and WB. It holds a copy of the
//   fetched instruction, decodes that copy into datapath controls, drives the
//   data-memory strobes with a ready handshake and counts retired instructions.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   instr      in  32   instruction word at the current PC (sampled only on IF -> ID)
//   Zero       in   1   ALU zero flag (sampled only on EX -> MEM)
//   mem_ready  in   1   data-memory access complete (used by LW/SW in MEM)
//   PCSrc      out  1   1 = PC + branch offset, 0 = PC + 4 (WB only)
//   ALUSrc     out  1   1 = immediate operand
//   RegWrite   out  1   register-file write enable (WB only)
//   MemToReg   out  1   1 = writeback from data-memory read data
//   loadPC     out  1   PC update strobe, one cycle in WB
//   MemRead    out  1   data-memory read strobe (MEM, LW)
//   MemWrite   out  1   data-memory write strobe (MEM, SW)
//   ALUCtrl    out  4   ALU operation
//   state      out  3   current FSM state, for debug
//   retired    out 32   retired-instruction count, wraps

module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  // FSM state encodings; 5..7 are illegal and fall back to IF.
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes recognised by the decoder.
  localparam logic [6:0] SW        = 7'b0100011;
  localparam logic [6:0] LW        = 7'b0000011;
  localparam logic [6:0] IMMEDIATE = 7'b0010011;
  localparam logic [6:0] BEQ       = 7'b1100011;
  localparam logic [6:0] RR        = 7'b0110011;

  // ALU operation codes.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  logic [2:0]  next_state;
  logic [31:0] ir;
  logic        zero_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b;
  logic        is_lw;
  logic        is_sw;
  logic        is_imm;
  logic        is_beq;
  logic        is_rr;
  logic        in_flight;
  logic [3:0]  alu_dec;

  // Register and immediate fields are consumed by the datapath, not by control.
  logic        unused_ir_fields;
  assign unused_ir_fields = ^{ir[31], ir[29:15], ir[11:7]};

  // ---------------------------------------------------------------------------
  // Decode of the held instruction
  // ---------------------------------------------------------------------------
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign f7b    = ir[30];

  assign is_lw  = (opcode == LW);
  assign is_sw  = (opcode == SW);
  assign is_imm = (opcode == IMMEDIATE);
  assign is_beq = (opcode == BEQ);
  assign is_rr  = (opcode == RR);

  // Unknown opcodes fall through every branch and decode as ADD with no side
  // effects, which makes them behave as NOPs.
  always_comb begin
    alu_dec = ALU_ADD;
    if (is_beq) begin
      alu_dec = ALU_SUB;
    end else if (is_rr || is_imm) begin
      case (funct3)
        3'b000:  alu_dec = (is_rr && f7b) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_dec = ALU_AND;
        3'b110:  alu_dec = ALU_OR;
        3'b100:  alu_dec = ALU_XOR;
        3'b010:  alu_dec = ALU_SLT;
        3'b001:  alu_dec = ALU_SLL;
        3'b101:  alu_dec = f7b ? ALU_SRA : ALU_SRL;
        default: alu_dec = ALU_ADD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF:    next_state = S_ID;
      S_ID:    next_state = S_EX;
      S_EX:    next_state = S_MEM;
      // Only real memory accesses wait on the handshake.
      S_MEM:   next_state = ((is_lw || is_sw) && !mem_ready) ? S_MEM : S_WB;
      S_WB:    next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IF;
      ir      <= 32'd0;
      zero_q  <= 1'b0;
      retired <= 32'd0;
    end else begin
      state <= next_state;
      // The instruction is captured once per instruction so that the fetch bus
      // may move on while the rest of the sequence executes.
      if (state == S_IF) begin
        ir <= instr;
      end
      // The branch decision is frozen at the end of EX; later Zero activity
      // belongs to other datapath operations.
      if (state == S_EX) begin
        zero_q <= Zero;
      end
      if (state == S_WB) begin
        retired <= retired + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // ID..WB hold a valid decoded instruction; IF and illegal states drive zeros.
  assign in_flight = (state == S_ID) || (state == S_EX) ||
                     (state == S_MEM) || (state == S_WB);

  assign ALUSrc   = in_flight && (is_lw || is_sw || is_imm);
  assign MemToReg = in_flight && is_lw;
  assign ALUCtrl  = in_flight ? alu_dec : 4'b0000;

  assign MemRead  = (state == S_MEM) && is_lw;
  assign MemWrite = (state == S_MEM) && is_sw;

  assign RegWrite = (state == S_WB) && (is_lw || is_imm || is_rr);
  assign loadPC   = (state == S_WB);
  assign PCSrc    = (state == S_WB) && is_beq && zero_q;

endmodule
